// File: rtl/video_pattern_gen.sv
// video_pattern_gen: framed test-pattern video source with programmable size and gaps
module video_pattern_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int SPARSE_IN   = 0,
  parameter int LINE_GAP    = 350,
  parameter int FRAME_GAP   = 2110
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [15:0]            line_size,
  input  logic [15:0]            frame_size,
  input  logic [1:0]             pattern,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   eof_o,
  output logic                   busy_o
);
  typedef enum logic [2:0] {IDLE, ACTIVE, SPACE, LGAP, FGAP} state_t;
  localparam logic [15:0] SP_LAST = 16'(SPARSE_IN - 1);
  localparam logic [15:0] LG_LAST = 16'(LINE_GAP - 1);
  localparam logic [15:0] FG_LAST = 16'(FRAME_GAP - 1);
  if (PIXEL_WIDTH < 8 || SPARSE_IN < 0 || LINE_GAP < 1 || FRAME_GAP < 1) begin : g_bad_param
    $error("video_pattern_gen: PIXEL_WIDTH must be >= 8 and gap parameters >= 1");
  end
  state_t                 state;
  logic [15:0]            x, y, cnt, lsz, fsz;
  logic [1:0]             pat;
  logic [7:0]             frame_cnt;
  logic [3:0]             xp1;
  logic [PIXEL_WIDTH-1:0] pix;
  logic                   act;
  assign xp1 = x[3:0] + 4'd1;
  assign act = state == ACTIVE;
  // pixel value for the current position, from the config latched at frame start
  always_comb
    pix = pat == 2'd0 ? PIXEL_WIDTH'({y[3:0], xp1}) :
          pat == 2'd1 ? PIXEL_WIDTH'(x + y) :
          pat == 2'd2 ? PIXEL_WIDTH'(x) : PIXEL_WIDTH'(frame_cnt);
  // frame sequencer; outputs are registered views of the state one cycle earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      cnt       <= '0;
      lsz       <= '0;
      fsz       <= '0;
      pat       <= '0;
      frame_cnt <= '0;
      do_o      <= '0;
      de_o      <= 1'b0;
      hs_o      <= 1'b0;
      vs_o      <= 1'b0;
      eof_o     <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      do_o   <= act ? pix : '0;
      de_o   <= act;
      hs_o   <= act && x == '0;
      vs_o   <= act && x == '0 && y == '0;
      eof_o  <= act && x == lsz && y == fsz;
      busy_o <= state != IDLE;
      case (state)
        IDLE: if (en) begin
          lsz   <= line_size;
          fsz   <= frame_size;
          pat   <= pattern;
          x     <= '0;
          y     <= '0;
          state <= ACTIVE;
        end
        ACTIVE: begin
          cnt <= '0;
          if (x == lsz) state <= y == fsz ? FGAP : LGAP;
          else if (SPARSE_IN > 0) state <= SPACE;
          else x <= x + 16'd1;
        end
        SPACE: if (cnt == SP_LAST) begin
          x     <= x + 16'd1;
          state <= ACTIVE;
        end else cnt <= cnt + 16'd1;
        LGAP: if (cnt == LG_LAST) begin
          x     <= '0;
          y     <= y + 16'd1;
          state <= ACTIVE;
        end else cnt <= cnt + 16'd1;
        FGAP: if (cnt == FG_LAST) begin
          frame_cnt <= frame_cnt + 8'd1;
          x         <= '0;
          y         <= '0;
          lsz       <= line_size;
          fsz       <= frame_size;
          pat       <= pattern;
          state     <= en ? ACTIVE : IDLE;
        end else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
